// File: rtl/bkm_control_iter_if.sv
// bkm_control_iter_if: step request/response bundle between bkm_control_iter and bkm_control_step.
interface bkm_control_iter_if #(
   parameter int W = 64,
   parameter int LOG2N = 5
);
   logic             step_req;
   logic [LOG2N-1:0] step_n;
   logic             step_mode;
   logic [1:0]       step_format;
   logic [1:0]       step_d_u_n;
   logic [1:0]       step_d_v_n;
   logic [W-1:0]     step_u_n;
   logic [W-1:0]     step_v_n;
   logic [W-1:0]     step_u_np1;
   logic [W-1:0]     step_v_np1;
   logic             step_ack;
   modport master (
      output step_req, step_n, step_mode, step_format, step_d_u_n, step_d_v_n, step_u_n, step_v_n,
      input  step_u_np1, step_v_np1, step_ack
   );
   modport slave (
      input  step_req, step_n, step_mode, step_format, step_d_u_n, step_d_v_n, step_u_n, step_v_n,
      output step_u_np1, step_v_np1, step_ack
   );
endinterface

// File: rtl/bkm_control_iter.sv
// bkm_control_iter: BKM iteration sequencer closing the loop around bkm_control_step.
// Optional step-ack watchdog enabled by defining BKM_ITER_ACK_TIMEOUT_EN.
module bkm_control_iter #(
   parameter int W = 64,
   parameter int N_ITER = 32,
   parameter int LOG2N = (N_ITER > 1) ? $clog2(N_ITER) : 1
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         enable,
   input  logic         start,
   input  logic         mode,
   input  logic [1:0]   format,
   input  logic [W-1:0] u_0,
   input  logic [W-1:0] v_0,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] u_res,
   output logic [W-1:0] v_res,
   output logic         err,
   bkm_control_iter_if.master step
);
   typedef enum logic [1:0] {IDLE, SEL, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [LOG2N-1:0] n_q, n_d;
   logic mode_q, mode_d, req_q, req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [1:0] format_q, format_d, d_u_q, d_u_d, d_v_q, d_v_d;
   logic [W-1:0] u_n_q, u_n_d, v_n_q, v_n_d, u_res_q, u_res_d, v_res_q, v_res_d;
`ifdef BKM_ITER_ACK_TIMEOUT_EN
   logic [7:0] wd_q, wd_d;
`endif
   // t is the top nibble of the residual; L-mode negates the E-mode digit
   function automatic logic [1:0] digit(input logic signed [3:0] t, input logic m);
      logic [1:0] e;
      e = (t >= 4'sd2) ? 2'b01 : (t <= -4'sd3) ? 2'b11 : 2'b00;
      return m ? 2'b00 - e : e;
   endfunction
   always_comb begin
      state_d = state_q;
      n_d = n_q;
      mode_d = mode_q;
      format_d = format_q;
      req_d = req_q;
      busy_d = busy_q;
      done_d = done_q;
      err_d = err_q;
      d_u_d = d_u_q;
      d_v_d = d_v_q;
      u_n_d = u_n_q;
      v_n_d = v_n_q;
      u_res_d = u_res_q;
      v_res_d = v_res_q;
`ifdef BKM_ITER_ACK_TIMEOUT_EN
      wd_d = wd_q;
`endif
      if (enable) begin
         req_d = 1'b0;
         done_d = 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_d = SEL;
               u_n_d = u_0;
               v_n_d = v_0;
               mode_d = mode;
               format_d = format;
               n_d = '0;
               busy_d = 1'b1;
               err_d = 1'b0;
            end
            SEL: begin
               d_u_d = digit(u_n_q[W-1:W-4], mode_q);
               d_v_d = digit(v_n_q[W-1:W-4], mode_q);
               req_d = 1'b1;
               state_d = WAIT;
`ifdef BKM_ITER_ACK_TIMEOUT_EN
               wd_d = '0;
`endif
            end
            WAIT: if (step.step_ack) begin
               u_n_d = step.step_u_np1;
               v_n_d = step.step_v_np1;
               if (n_q == LOG2N'(N_ITER - 1)) begin
                  u_res_d = step.step_u_np1;
                  v_res_d = step.step_v_np1;
                  busy_d = 1'b0;
                  done_d = 1'b1;
                  state_d = DONE;
               end else begin
                  n_d = n_q + 1'b1;
                  state_d = SEL;
               end
            end
`ifdef BKM_ITER_ACK_TIMEOUT_EN
            // 254 cycles already counted, so this is the 255th ack-less WAIT cycle
            else if (wd_q == 8'd254) begin
               err_d = 1'b1;
               busy_d = 1'b0;
               state_d = IDLE;
            end else wd_d = wd_q + 8'd1;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= IDLE;
         n_q <= '0;
         mode_q <= 1'b0;
         format_q <= '0;
         req_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         d_u_q <= '0;
         d_v_q <= '0;
         u_n_q <= '0;
         v_n_q <= '0;
         u_res_q <= '0;
         v_res_q <= '0;
`ifdef BKM_ITER_ACK_TIMEOUT_EN
         wd_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q <= n_d;
         mode_q <= mode_d;
         format_q <= format_d;
         req_q <= req_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q <= err_d;
         d_u_q <= d_u_d;
         d_v_q <= d_v_d;
         u_n_q <= u_n_d;
         v_n_q <= v_n_d;
         u_res_q <= u_res_d;
         v_res_q <= v_res_d;
`ifdef BKM_ITER_ACK_TIMEOUT_EN
         wd_q <= wd_d;
`endif
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign err = err_q;
   assign u_res = u_res_q;
   assign v_res = v_res_q;
   assign step.step_req = req_q;
   assign step.step_n = n_q;
   assign step.step_mode = mode_q;
   assign step.step_format = format_q;
   assign step.step_d_u_n = d_u_q;
   assign step.step_d_v_n = d_v_q;
   assign step.step_u_n = u_n_q;
   assign step.step_v_n = v_n_q;
endmodule

// File: tb/tb_bkm_control_iter.sv
// tb_bkm_control_iter: directed and randomized checks of bkm_control_iter against a digit/latency model.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end
module tb_bkm_control_iter;
   localparam int W = 16, N = 4, LOG2N = 2;
   logic clk = 1'b0;
   logic srst, enable, start, mode, busy, done, err;
   logic [1:0] format;
   logic [W-1:0] u_0, v_0, u_res, v_res, last_u;
   int checks = 0, failures = 0;
   bkm_control_iter_if #(.W(W), .LOG2N(LOG2N)) step ();
   bkm_control_iter #(.W(W), .N_ITER(N), .LOG2N(LOG2N)) dut (
      .clk(clk), .srst(srst), .enable(enable), .start(start), .mode(mode), .format(format),
      .u_0(u_0), .v_0(v_0), .busy(busy), .done(done), .u_res(u_res), .v_res(v_res), .err(err),
      .step(step)
   );
   always #5 clk = ~clk;
   function automatic logic [1:0] exp_digit(input logic [W-1:0] u, input logic m);
      int t, d;
      t = int'($signed(u)) >>> (W - 4);
      d = (t >= 2) ? 1 : (t <= -3) ? -1 : 0;
      if (m) d = -d;
      return (d == 1) ? 2'b01 : (d == -1) ? 2'b11 : 2'b00;
   endfunction
   task automatic run_op(input logic [W-1:0] u0, input logic [W-1:0] v0, input logic m, input int lat,
                         input logic [1:0] exp_du0, input bit stray, input int freeze_it, input int abort_it);
      logic [W-1:0] cu, cv, nu, nv;
      logic [1:0] fmt;
      int it, cnt, cyc, reqs, exp_cyc;
      bit pending, frozen, fin, seen_done;
      fmt = 2'($urandom);
      exp_cyc = N * (lat + 2) + 1 + ((freeze_it >= 0) ? 5 : 0);
      @(negedge clk);
      start = 1'b1; mode = m; format = fmt; u_0 = u0; v_0 = v0;
      @(posedge clk); cyc = 1;
      @(negedge clk);
      start = 1'b0; mode = ~m; format = ~fmt; u_0 = W'($urandom); v_0 = W'($urandom);
      `CHK("busy_after_start", busy, 1'b1)
      cu = u0; cv = v0; it = 0; cnt = 0; reqs = 0; pending = 0; frozen = 0; fin = 0;
      while (!fin && cyc < 200) begin
         if (done) begin
            checks++;
            if (cyc !== exp_cyc) begin
               failures++;
               $error("FAIL done_cycles observed=%0d expected=%0d", cyc, exp_cyc);
            end
            `CHK("u_res", u_res, cu)
            `CHK("v_res", v_res, cv)
            `CHK("busy_at_done", busy, 1'b0)
            `CHK("err_at_done", err, 1'b0)
            `CHK("req_count", reqs, N)
            start = stray;
            step.step_ack = 1'b0;
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            `CHK("idle_after_done", {busy, done, step.step_req}, 3'b000)
            last_u = cu;
            fin = 1;
         end else begin
            start = stray;
            if (step.step_req) begin
               `CHK("step_n", step.step_n, LOG2N'(it))
               `CHK("d_u", step.step_d_u_n, exp_digit(cu, m))
               `CHK("d_v", step.step_d_v_n, exp_digit(cv, m))
               `CHK("u_n", step.step_u_n, cu)
               `CHK("v_n", step.step_v_n, cv)
               `CHK("mode_fmt", {step.step_mode, step.step_format}, {m, fmt})
               if (it == 0) `CHK("d_u_n0", step.step_d_u_n, exp_du0)
               reqs++; pending = 1; cnt = 0;
               if (it == abort_it) begin
                  srst = 1'b1; start = 1'b0; step.step_ack = 1'b0;
                  @(posedge clk); @(negedge clk);
                  srst = 1'b0;
                  `CHK("abort_ctl", {busy, done, step.step_req, err}, 4'b0000)
                  `CHK("abort_n_d", {step.step_n, step.step_d_u_n, step.step_d_v_n}, 6'd0)
                  `CHK("abort_data", {step.step_u_n, step.step_v_n, u_res, v_res}, 64'd0)
                  seen_done = 0;
                  repeat (3 * N + 4) begin
                     @(posedge clk); @(negedge clk);
                     if (done) seen_done = 1;
                  end
                  `CHK("abort_no_done", seen_done, 1'b0)
                  return;
               end
               if (it == freeze_it && !frozen) begin
                  enable = 1'b0;
                  repeat (5) begin
                     step.step_ack = 1'b1; step.step_u_np1 = W'($urandom); step.step_v_np1 = W'($urandom);
                     @(posedge clk); cyc++; @(negedge clk);
                     `CHK("frozen_ctl", {step.step_req, busy, done}, 3'b110)
                     `CHK("frozen_n", step.step_n, LOG2N'(it))
                     `CHK("frozen_u_n", step.step_u_n, cu)
                  end
                  enable = 1'b1; frozen = 1;
               end
            end
            if (pending && cnt == lat) begin
               nu = W'($urandom); nv = W'($urandom);
               step.step_ack = 1'b1; step.step_u_np1 = nu; step.step_v_np1 = nv;
               cu = nu; cv = nv; it++; pending = 0;
            end else begin
               step.step_ack = 1'b0;
               if (pending) cnt++;
            end
            @(posedge clk); cyc++; @(negedge clk);
         end
      end
      if (!fin) `CHK("op_timeout", cyc, exp_cyc)
      start = 1'b0;
      step.step_ack = 1'b0;
   endtask
   initial begin
      srst = 1'b1; enable = 1'b1; start = 1'b0; mode = 1'b0; format = 2'b00;
      u_0 = '0; v_0 = '0; last_u = '0;
      step.step_ack = 1'b0; step.step_u_np1 = '0; step.step_v_np1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      srst = 1'b0;
      checks++;
      if ({busy, done, err, step.step_req} !== 4'b0000) begin
         failures++;
         $error("FAIL rst_ctl observed=%0h expected=0", {busy, done, err, step.step_req});
      end
      `CHK("rst_res", {u_res, v_res}, 32'd0)
      `CHK("rst_step", {step.step_n, step.step_mode, step.step_format, step.step_d_u_n, step.step_d_v_n}, 9'd0)
      `CHK("rst_un", {step.step_u_n, step.step_v_n}, 32'd0)
      run_op(16'h3000, 16'h0000, 1'b0, 0, 2'b01, 0, -1, -1);
      run_op(16'h3000, 16'h0000, 1'b1, 0, 2'b11, 0, -1, -1);
      run_op(16'hC000, 16'h1000, 1'b1, 0, 2'b01, 0, -1, -1);
      run_op(16'hE000, 16'hD000, 1'b1, 0, 2'b00, 0, -1, -1);
      run_op(16'h5A5A, 16'hA5A5, 1'b0, 3, 2'b01, 0, -1, -1);
      run_op(16'h7000, 16'h8000, 1'b0, 1, 2'b01, 0, -1, 2);
      run_op(16'hB000, 16'h2000, 1'b0, 2, 2'b11, 0, -1, -1);
      repeat (3) begin
         step.step_ack = 1'b1; step.step_u_np1 = W'($urandom); step.step_v_np1 = W'($urandom);
         @(posedge clk); @(negedge clk);
         `CHK("stray_ack_busy", busy, 1'b0)
         `CHK("stray_ack_u_n", step.step_u_n, last_u)
      end
      step.step_ack = 1'b0;
      run_op(16'h2000, 16'hE000, 1'b0, 3, 2'b01, 1, 1, -1);
      repeat (8) begin
         logic [W-1:0] ru, rv;
         logic rm;
         ru = W'($urandom); rv = W'($urandom); rm = 1'($urandom);
         run_op(ru, rv, rm, int'($urandom_range(0, 3)), exp_digit(ru, rm), 1'($urandom), -1, -1);
      end
`ifdef BKM_ITER_ACK_TIMEOUT_EN
      begin
         int k;
         bit seen;
         @(negedge clk);
         start = 1'b1; u_0 = 16'h4000; v_0 = 16'h0000; mode = 1'b0;
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         k = 0;
         while (!step.step_req && k < 10) begin @(posedge clk); k++; @(negedge clk); end
         `CHK("to_req_seen", step.step_req, 1'b1)
         k = 0; seen = 0;
         while (!err && k < 400) begin
            @(posedge clk); k++; @(negedge clk);
            if (done) seen = 1;
         end
         checks++;
         if (k !== 255) begin
            failures++;
            $error("FAIL to_wait_cycles observed=%0d expected=255", k);
         end
         `CHK("to_flags", {err, busy, seen}, 3'b100)
         start = 1'b1;
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         `CHK("to_err_clear", {err, busy}, 2'b01)
         srst = 1'b1;
         @(posedge clk); @(negedge clk);
         srst = 1'b0;
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
